// File: rtl/ccd_link_pkg.sv
// ccd_link_pkg: host-link frame constants shared by the TX mux and RX demux,
// plus the rx_demux parser state encoding.
package ccd_link_pkg;
   localparam int FRAME_LEN  = 3;
   localparam int HDR_BASE   = 1;
   localparam int NUM_CH_DEF = 4;
   localparam int CH_W       = 2;
   typedef enum logic [1:0] {ST_HDR, ST_MSB, ST_LSB, ST_DELIVER} rx_state_e;
endpackage

// File: rtl/rx_demux_if.sv
// rx_demux_if: RX FIFO side and per-channel output side of the frame demux.
interface rx_demux_if;
   logic [7:0]  rdata;
   logic        rempty;
   logic        rinc;
   logic [15:0] out_0;
   logic [15:0] out_1;
   logic [15:0] out_2;
   logic [15:0] out_3;
   logic [3:0]  valid;
   logic [3:0]  ack;
   logic        err_hdr;
   logic        err_timeout;
   modport slave (
      input  rdata, rempty, ack,
      output rinc, out_0, out_1, out_2, out_3, valid, err_hdr, err_timeout
   );
   modport master (
      output rdata, rempty, ack,
      input  rinc, out_0, out_1, out_2, out_3, valid, err_hdr, err_timeout
   );
endinterface

// File: rtl/link_idle_timer.sv
// link_idle_timer: counts idle cycles while en is high; expired flags the last
// allowed idle cycle so the caller can abort in that same cycle.
module link_idle_timer #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT_CYCLES + 1);
   logic [W-1:0] cnt_q, cnt_d;
   assign expired = en && cnt_q == W'(TIMEOUT_CYCLES - 1);
   always_comb cnt_d = clr ? '0 : en ? cnt_q + W'(1) : cnt_q;
   always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
endmodule

// File: rtl/rx_demux.sv
// rx_demux: parses 3-byte frames (header 1..NUM_CH, MSB, LSB) from the RX FIFO into
// per-channel valid/ack output words. RX_DEMUX_TIMEOUT_EN aborts stalled partial frames.
module rx_demux
   import ccd_link_pkg::*;
#(
   parameter int NUM_CH         = NUM_CH_DEF,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic       clk,
   input logic       rst_n,
   rx_demux_if.slave bus
);
   rx_state_e        state_q, state_d;
   logic [CH_W-1:0]  ch_q, ch_d;
   logic [15:0]      word_q, word_d;
   logic [3:0][15:0] out_q, out_d;
   logic [3:0]       valid_q, valid_d, load;
   logic             err_hdr_q, err_to_q, pop, hdr_ok, deliver, expired;

   assign pop     = state_q != ST_DELIVER && !bus.rempty;
   assign hdr_ok  = bus.rdata >= 8'(HDR_BASE) && bus.rdata < 8'(HDR_BASE + NUM_CH);
   // an ack in the delivery cycle frees the slot, so the load may overwrite it
   assign deliver = state_q == ST_DELIVER && (!valid_q[ch_q] || bus.ack[ch_q]);
   assign load    = deliver ? 4'b0001 << ch_q : 4'b0000;

`ifdef RX_DEMUX_TIMEOUT_EN
   link_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      ((state_q == ST_MSB || state_q == ST_LSB) && bus.rempty),
      .clr     (pop || state_d != state_q),
      .expired (expired)
   );
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign expired        = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      word_d  = word_q;
      case (state_q)
         ST_HDR: begin
            if (pop && hdr_ok) begin
               ch_d    = CH_W'(bus.rdata - 8'(HDR_BASE));
               state_d = ST_MSB;
            end
         end
         ST_MSB: begin
            if (pop) begin
               word_d[15:8] = bus.rdata;
               state_d      = ST_LSB;
            end else if (expired) state_d = ST_HDR;
         end
         ST_LSB: begin
            if (pop) begin
               word_d[7:0] = bus.rdata;
               state_d     = ST_DELIVER;
            end else if (expired) state_d = ST_HDR;
         end
         default: state_d = deliver ? ST_HDR : ST_DELIVER;
      endcase
      valid_d = load | (valid_q & ~bus.ack);
      for (int n = 0; n < 4; n++) out_d[n] = load[n] ? word_q : out_q[n];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_HDR;
         ch_q      <= '0;
         word_q    <= '0;
         out_q     <= '0;
         valid_q   <= '0;
         err_hdr_q <= 1'b0;
         err_to_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         word_q    <= word_d;
         out_q     <= out_d;
         valid_q   <= valid_d;
         err_hdr_q <= state_q == ST_HDR && pop && !hdr_ok;
         err_to_q  <= expired;
      end
   end

   assign bus.rinc        = pop;
   assign bus.out_0       = out_q[0];
   assign bus.out_1       = out_q[1];
   assign bus.out_2       = out_q[2];
   assign bus.out_3       = out_q[3];
   assign bus.valid       = valid_q;
   assign bus.err_hdr     = err_hdr_q;
   assign bus.err_timeout = err_to_q;
endmodule

// File: tb/tb_rx_demux.sv
// tb_rx_demux: directed and randomized frames against a byte-stream reference model.
module tb_rx_demux;
   localparam int TO = 8;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rx_demux_if bus();
   rx_demux #(.NUM_CH(4), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int          n_cmp = 0, n_err = 0, hdr_pulses = 0, to_pulses = 0, idle = 0;
   logic [7:0]  fifo[$];
   logic [7:0]  part[$];
   logic [15:0] mout[4];
   logic [3:0]  mvalid;
   logic        have_word, merr_hdr, merr_to;
   logic [1:0]  wch;
   logic [15:0] wword;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      mvalid = '0;
      for (int i = 0; i < 4; i++) mout[i] = '0;
      part.delete();
      have_word = 1'b0;
      merr_hdr = 1'b0;
      merr_to = 1'b0;
      idle = 0;
   endfunction

   // one clock: drive inputs, check rinc, advance the model at the edge, check registers
   task automatic step(input logic [3:0] a, input logic r = 1'b1);
      logic       exp_rinc;
      logic [7:0] b;
      b = 8'h00;
      bus.ack = a;
      rst_n = r;
      bus.rempty = fifo.size() == 0;
      bus.rdata = fifo.size() != 0 ? fifo[0] : 8'($urandom);
      #1;
      exp_rinc = fifo.size() != 0 && !have_word;
      check("rinc", bus.rinc, exp_rinc);
      @(posedge clk);
      if (exp_rinc) b = fifo.pop_front();
      if (!r) model_reset();
      else begin
         merr_hdr = 1'b0;
         merr_to = 1'b0;
         if (have_word && (!mvalid[wch] || a[wch])) begin
            mvalid = (mvalid & ~a) | (4'b0001 << wch);
            mout[wch] = wword;
            have_word = 1'b0;
         end else begin
            mvalid = mvalid & ~a;
            if (exp_rinc) begin
               idle = 0;
               if (part.size() == 0 && (b < 8'd1 || b > 8'd4)) merr_hdr = 1'b1;
               else part.push_back(b);
               if (part.size() == 3) begin
                  have_word = 1'b1;
                  wch = 2'(part[0] - 8'd1);
                  wword = {part[1], part[2]};
                  part.delete();
               end
            end
`ifdef RX_DEMUX_TIMEOUT_EN
            else if (part.size() != 0) begin
               idle++;
               if (idle == TO) begin
                  part.delete();
                  idle = 0;
                  merr_to = 1'b1;
               end
            end
`endif
         end
      end
      #1;
      check("valid", bus.valid, mvalid);
      check("out_0", bus.out_0, mout[0]);
      check("out_1", bus.out_1, mout[1]);
      check("out_2", bus.out_2, mout[2]);
      check("out_3", bus.out_3, mout[3]);
      check("err_hdr", bus.err_hdr, merr_hdr);
      check("err_timeout", bus.err_timeout, merr_to);
      hdr_pulses += int'(bus.err_hdr);
      to_pulses += int'(bus.err_timeout);
   endtask

   initial begin
      bus.ack = '0;
      bus.rempty = 1'b1;
      bus.rdata = '0;
      model_reset();
      @(posedge clk);
      #1;
      step(4'h0, 1'b0);
      check("rst_valid", bus.valid, 4'h0);
      check("rst_out_0", bus.out_0, 16'h0000);
      check("rst_err_hdr", bus.err_hdr, 1'b0);

      fifo = '{8'h02, 8'hAB, 8'hCD};
      repeat (4) step(4'h0);
      check("clean_out_1", bus.out_1, 16'hABCD);
      check("clean_valid", bus.valid, 4'b0010);
      step(4'b0010);
      check("clean_ack", bus.valid, 4'b0000);

      hdr_pulses = 0;
      fifo = '{8'h00, 8'h07, 8'h01, 8'h12, 8'h34};
      repeat (6) step(4'h0);
      check("illegal_pulses", hdr_pulses, 2);
      check("illegal_out_0", bus.out_0, 16'h1234);
      check("illegal_valid0", bus.valid[0], 1'b1);
      step(4'b0001);

      fifo = '{8'h04, 8'h11, 8'h22, 8'h04, 8'h33, 8'h44, 8'h02};
      repeat (4) step(4'h0);
      check("bp_first", bus.out_3, 16'h1122);
      repeat (6) step(4'h0);
      check("bp_held", bus.out_3, 16'h1122);
      step(4'b1000);
      check("bp_second", bus.out_3, 16'h3344);
      check("bp_valid3", bus.valid[3], 1'b1);
      fifo.push_back(8'hAA);
      fifo.push_back(8'hBB);
      repeat (6) step(4'hF);

      fifo = '{8'h04, 8'h55, 8'h66};
      repeat (4) step(4'h0);
      fifo = '{8'h04, 8'h77, 8'h88};
      repeat (3) step(4'h0);
      step(4'b1000);
      check("simul_out_3", bus.out_3, 16'h7788);
      check("simul_valid3", bus.valid[3], 1'b1);
      repeat (2) step(4'hF);

      fifo = '{8'h03, 8'h55};
      repeat (2) step(4'h0);
      step(4'h0, 1'b0);
      check("midrst_valid", bus.valid, 4'h0);
      check("midrst_out_3", bus.out_3, 16'h0000);
      fifo.push_back(8'h66);
      step(4'h0);
      check("midrst_resync", bus.err_hdr, 1'b1);

`ifdef RX_DEMUX_TIMEOUT_EN
      fifo = '{8'h01, 8'h99};
      repeat (2) step(4'h0);
      to_pulses = 0;
      repeat (7) step(4'h0);
      check("to_early", to_pulses, 0);
      step(4'h0);
      check("to_fire", bus.err_timeout, 1'b1);
      fifo = '{8'h01, 8'h00, 8'h01};
      repeat (4) step(4'h0);
      check("to_recover", bus.out_0, 16'h0001);
`endif

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0 && fifo.size() < 12) begin
            if ($urandom_range(0, 9) == 0) fifo.push_back(8'($urandom));
            else begin
               fifo.push_back(8'($urandom_range(1, 4)));
               fifo.push_back(8'($urandom));
               fifo.push_back(8'($urandom));
            end
         end
         step(4'($urandom & $urandom), $urandom_range(0, 299) != 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/rx_demux.md
# rx_demux

Receive-side frame demultiplexer for the host link. It pops bytes from the RX FIFO and parses 3-byte frames: a header byte carrying channel code 1..4, then data MSB, then data LSB. Each reassembled 16-bit word is delivered to one of four channel output registers with a valid/ack handshake. It is the counterpart of the TX priority multiplexer and uses the same frame format and channel numbering.

## Interface
Parameters:
- NUM_CH, 4: number of channels; header codes are 1..NUM_CH.
- TIMEOUT_CYCLES, 1024: maximum idle cycles allowed inside a partial frame. Used only with RX_DEMUX_TIMEOUT_EN.

Ports:
- clk  in  1: single clock; all logic is on the rising edge.
- rst_n  in  1: synchronous, active-low reset.
- rdata  in  8: RX FIFO head byte. First-word fall-through: valid whenever rempty=0.
- rempty  in  1: RX FIFO empty, active high.
- rinc  out  1: RX FIFO pop, active high, one byte per cycle.
- out_0..out_3  out  16 each: per-channel received word, held stable while the channel's valid bit is high.
- valid  out  4: per-channel word-available flag.
- ack  in  4: per-channel consume; ack[n] is sampled only while valid[n]=1.
- err_hdr  out  1: one-cycle pulse when an illegal header byte is dropped.
- err_timeout  out  1: one-cycle pulse when a partial frame is aborted.

## Operation
- States:
  - HDR: wait for the header byte.
  - MSB: wait for the data MSB.
  - LSB: wait for the data LSB.
  - DELIVER: load the word into its channel output.
- rinc = (state is HDR, MSB or LSB) AND rempty=0. This is combinational; rinc is never high in DELIVER.
- HDR with a pop:
  - rdata in 1..NUM_CH: latch ch = rdata-1 and go to MSB.
  - Any other value (0x00, 0x05..0xFF): drop the byte, pulse err_hdr, stay in HDR. This is the resync mechanism.
- MSB with a pop: latch word[15:8], go to LSB.
- LSB with a pop: latch word[7:0], go to DELIVER.
- DELIVER:
  - If valid[ch]=0, or valid[ch]=1 with ack[ch]=1 in the same cycle: out_ch <= word, valid[ch] <= 1, go to HDR.
  - Otherwise stay in DELIVER. This is back-pressure: no further pops happen, so the FIFO fills upstream.
- Channel valid/ack:
  - ack[n] with valid[n]=1 and no simultaneous load clears valid[n] at the next edge.
  - A simultaneous ack and load for the same channel leaves valid[n]=1 with the new word.
  - ack on a channel with valid=0 is ignored.
- Channels are independent. A channel with valid=1 stalls the demux only when a new frame targets that channel.
- Reset with rst_n=0 at any edge:
  - state <= HDR, all valid <= 0, all out_n <= 0, err pulses <= 0.
  - Any partial frame is discarded. Bytes not yet popped stay in the FIFO.

## Timing
- Reset values: rinc=0 (state HDR, follows rempty after reset), valid=4'h0, out_0..out_3=16'h0000, err_hdr=0, err_timeout=0.
- Back-to-back frames with the FIFO never empty and no stall:
  - Pops occur in cycles k, k+1, k+2; DELIVER occupies k+3.
  - valid[ch] goes high after the edge ending k+3, and the next header pop is in k+4.
  - Throughput is 3 bytes per 4 cycles.
- An empty FIFO in HDR/MSB/LSB holds the state with no pop. Waiting is unbounded unless the timeout is compiled in.
- err_hdr and err_timeout are registered and high for exactly one cycle after the triggering edge.

## Configuration
- RX_DEMUX_TIMEOUT_EN defined:
  - An idle counter runs in MSB and LSB. It increments each cycle with rempty=1 and clears on any pop or on a state change.
  - When it reaches TIMEOUT_CYCLES-1 with rempty still 1: go to HDR, pulse err_timeout, discard the partial frame.
  - DELIVER is never timed out.
- Not defined: no counter is built and err_timeout is tied to 0.

## Structure
- Shared package ccd_link_pkg holds the constants:
  - Frame length (3).
  - Header code base (1).
  - NUM_CH default.
  - State encodings for rx_demux (HDR, MSB, LSB, DELIVER).
- One sub-module, link_idle_timer, holds the timeout counter.
  - Inputs: clk, rst_n, en, clr.
  - Output: expired.
  - It is instantiated only under RX_DEMUX_TIMEOUT_EN.

## Test plan
- Clean frame: FIFO holds 0x02,0xAB,0xCD with ack=0 → one rinc per byte; after DELIVER, out_1=16'hABCD, valid=4'b0010. Pulse ack[1] → valid=4'b0000 next cycle.
- Illegal headers: bytes 0x00,0x07,0x01,0x12,0x34 → err_hdr pulses twice; out_0=16'h1234, valid[0]=1.
- Back-pressure: two frames for channel 3 (0x04,0x11,0x22 then 0x04,0x33,0x44), ack low → out_3=16'h1122. Demux holds in DELIVER with rinc=0 and the FIFO is not drained further. Pulse ack[3] → out_3=16'h3344, valid[3] stays 1.
- Simultaneous ack/load: ack[3] is asserted in the same cycle DELIVER loads channel 3 → valid[3] stays 1 and out_3 updates.
- Reset mid-frame: pop 0x03,0x55, then rst_n=0 for one cycle → valid=0, outs=0. Next byte 0x66 is treated as a header: err_hdr pulses.
- Timeout (macro defined, TIMEOUT_CYCLES=8): 0x01,0x99 then FIFO empty → err_timeout after 8 empty cycles. A following 0x01,0x00,0x01 yields out_0=16'h0001.
